// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one instruction-memory read
// at a time and hands the returned word (or a misalignment fault) to decode
// through a valid/ready handshake.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        fetch_fault,
    input  logic [2:0]  pc_sel,
    input  logic [31:0] branch_target,
    input  logic [31:0] jump_target,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc
);

    typedef logic [31:0] raw_instr_t;

    typedef enum logic [2:0] {
        PC_PLUS_4 = 3'b000,
        PC_BRANCH = 3'b001,
        PC_JUMP   = 3'b010,
        PC_MTVEC  = 3'b011,
        PC_MEPEC  = 3'b100
    } pc_next_t;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        VALID = 2'd2,
        FAULT = 2'd3
    } state_t;

    // addi x0,x0,0 presented in place of a fetch that could not be issued
    localparam raw_instr_t NOP_INSTR = 32'h0000_0013;

    state_t      state_reg;
    state_t      state_next;
    logic [31:0] pc_reg;
    raw_instr_t  instr_reg;
    logic [31:0] instr_pc_reg;
    // Low during reset and for the first cycle after it, so no request is
    // raised until the first rising edge following reset release.
    logic        active_reg;

    logic [31:0] next_pc;
    logic        next_misaligned;
    logic        handshake;

    // Next-PC selection; unknown codes fall back to sequential fetch
    always_comb begin
        next_pc = pc_reg + 32'd4;
        case (pc_sel)
            PC_PLUS_4: next_pc = pc_reg + 32'd4;
            PC_BRANCH: next_pc = branch_target;
            PC_JUMP:   next_pc = jump_target;
            PC_MTVEC:  next_pc = mtvec & 32'hFFFF_FFFC;
            PC_MEPEC:  next_pc = mepc;
            default:   next_pc = pc_reg + 32'd4;
        endcase
        next_misaligned = (next_pc[1:0] != 2'b00);
    end

    // Fetch FSM: next state and handshake/request outputs (state only, no
    // combinational path from instr_ready to imem_req)
    always_comb begin
        state_next  = state_reg;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        fetch_fault = 1'b0;
        handshake   = 1'b0;
        case (state_reg)
            REQ: begin
                imem_req = active_reg;
                if (active_reg && imem_gnt) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_next = VALID;
                end
            end
            VALID: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    handshake  = 1'b1;
                    state_next = next_misaligned ? FAULT : REQ;
                end
            end
            FAULT: begin
                instr_valid = 1'b1;
                fetch_fault = 1'b1;
                if (instr_ready) begin
                    handshake  = 1'b1;
                    state_next = next_misaligned ? FAULT : REQ;
                end
            end
            default: state_next = REQ;
        endcase
    end

    // State, PC and output holding registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= REQ;
            pc_reg       <= RESET_PC;
            instr_reg    <= '0;
            instr_pc_reg <= '0;
            active_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            active_reg <= 1'b1;
            if (state_reg == WAIT && imem_rvalid) begin
                instr_reg    <= imem_rdata;
                instr_pc_reg <= pc_reg;
            end
            if (handshake) begin
                pc_reg <= next_pc;
                // A misaligned target never reaches memory; the fault
                // entry carries the offending PC and a NOP word instead.
                if (next_misaligned) begin
                    instr_reg    <= NOP_INSTR;
                    instr_pc_reg <= next_pc;
                end
            end
        end
    end

    assign imem_addr = pc_reg;
    assign instr     = instr_reg;
    assign instr_pc  = instr_pc_reg;

endmodule
